wimax_derandomizer: RTL and testbench

Receive-side bit-serial PRBS derandomizer for the 802.16 PHY chain. It sits between the demodulator/FEC-decoder output and the MAC burst parser. It XORs each received bit with the 1+x^14+x^15 sequence to undo the transmit randomizer. The LFSR is reseeded at every burst start, and the block provides a ready/valid handshake with burst framing.

---
 rtl/wimax_derandomizer_pkg.sv | 32 +++
 rtl/wimax_derandomizer_if.sv | 31 +++
 rtl/wimax_derandomizer_prbs15_lfsr.sv | 32 +++
 rtl/wimax_derandomizer.sv | 138 +++++++++++++
 tb/tb_wimax_derandomizer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wimax_derandomizer_pkg.sv
// Shared definitions for the 802.16 PRBS derandomizer: seed, LFSR geometry,
// FSM states and a single-step LFSR function reusable on the transmit side.
package wimax_pkg;

  localparam int LFSR_W = 15;

  // Taps for 1 + x^14 + x^15, with s[14] holding stage 1.
  localparam int TAP_A = 1;
  localparam int TAP_B = 0;

  localparam logic [LFSR_W-1:0] SEED_DEFAULT = 15'h3715;
  localparam logic [15:0]       MAX_BITS     = 16'd9600;
  localparam int                CNT_W        = $bits(MAX_BITS);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } derand_state_t;

  typedef struct packed {
    logic [LFSR_W-1:0] state;
    logic              bit_out;
  } lfsr_step_t;

  function automatic lfsr_step_t lfsr_step(input logic [LFSR_W-1:0] s);
    lfsr_step_t r;
    r.bit_out = s[TAP_A] ^ s[TAP_B];
    r.state   = {r.bit_out, s[LFSR_W-1:1]};
    return r;
  endfunction

endpackage

// File: rtl/wimax_derandomizer_if.sv
// Bit-serial burst stream into and out of the derandomizer.
interface wimax_derandomizer_if;

  // Handshake: a bit moves across a port on a rising edge where valid and
  // ready are both high. Once valid is raised it holds data/sop/eop stable
  // until that edge; ready may change freely and never waits on valid.
  logic in_valid;
  logic in_data;
  logic in_sop;
  logic in_eop;
  logic in_ready;

  logic out_valid;
  logic out_data;
  logic out_sop;
  logic out_eop;
  logic out_ready;

  // master: the surrounding chain (drives input bits, consumes output bits)
  modport master (
    output in_valid, in_data, in_sop, in_eop, out_ready,
    input  in_ready, out_valid, out_data, out_sop, out_eop
  );

  // slave: the derandomizer itself
  modport slave (
    input  in_valid, in_data, in_sop, in_eop, out_ready,
    output in_ready, out_valid, out_data, out_sop, out_eop
  );

endinterface

// File: rtl/wimax_derandomizer_prbs15_lfsr.sv
// 15-stage PRBS generator for 1 + x^14 + x^15; when load is high the seed
// replaces the state before fb is formed, so the first bit uses the seed.
module prbs15_lfsr
  import wimax_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              adv,
  output logic              fb
);

  logic [LFSR_W-1:0] s;
  logic [LFSR_W-1:0] base;
  lfsr_step_t        step;

  assign base = load ? seed : s;
  assign step = lfsr_step(base);
  assign fb   = step.bit_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s <= SEED_DEFAULT;
    end else if (adv) begin
      s <= step.state;
    end else if (load) begin
      s <= seed;
    end
  end

endmodule

// File: rtl/wimax_derandomizer.sv
// Receive-side 802.16 bit-serial derandomizer with burst framing.
// Optional burst length checking is built when DERAND_LENCHK_EN is defined.
module wimax_derandomizer
  import wimax_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 seed_sel,
  input  logic [LFSR_W-1:0]    load,
  input  logic [CNT_W-1:0]     burst_bits,
  wimax_derandomizer_if.slave  bus,
  output logic                 len_err,
  output logic [7:0]           drop_cnt,
  output derand_state_t        dbg_state
);

  derand_state_t state;
  derand_state_t state_nxt;

  logic accept;
  logic emit;
  logic seed_load;
  logic fb;

  // A new bit is taken whenever the single output register is free or
  // being drained this cycle.
  assign bus.in_ready = en & (~bus.out_valid | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign emit         = accept & (bus.in_sop | (state == RUN));
  assign seed_load    = accept & bus.in_sop;
  assign dbg_state    = state;

  prbs15_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (seed_load),
    .seed  (seed_sel ? load : SEED_DEFAULT),
    .adv   (emit),
    .fb    (fb)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && bus.in_sop && !bus.in_eop) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (accept && bus.in_eop) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= 1'b0;
      bus.out_sop   <= 1'b0;
      bus.out_eop   <= 1'b0;
    end else if (emit) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= bus.in_data ^ fb;
      bus.out_sop   <= bus.in_sop;
      bus.out_eop   <= bus.in_eop;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  // Bits arriving between bursts are discarded and counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= 8'd0;
    end else if (accept && !bus.in_sop && (state == IDLE) && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

`ifdef DERAND_LENCHK_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt_now;
  logic             len_bad;

  // cnt_now is the position of the bit being accepted within its burst.
  always_comb begin
    cnt_now = (bit_cnt == '1) ? bit_cnt : bit_cnt + CNT_ONE;
    if (bus.in_sop) begin
      cnt_now = CNT_ONE;
    end
    len_bad = 1'b0;
    if (bus.in_sop && (state == RUN)) begin
      len_bad = 1'b1;
    end
    if (bus.in_eop && (cnt_now != burst_bits)) begin
      len_bad = 1'b1;
    end
    if (!bus.in_eop && (cnt_now == burst_bits)) begin
      len_bad = 1'b1;
    end
  end

  // An error raised by a SOP takes precedence over the clear that SOP brings.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt <= '0;
      len_err <= 1'b0;
    end else if (emit) begin
      bit_cnt <= cnt_now;
      if (len_bad) begin
        len_err <= 1'b1;
      end else if (bus.in_sop) begin
        len_err <= 1'b0;
      end
    end
  end
`else
  logic len_unused;
  assign len_unused = ^burst_bits;
  assign len_err    = 1'b0;
`endif

endmodule

// File: tb/tb_wimax_derandomizer.sv
// Directed bench for wimax_derandomizer using the 802.16 96-bit reference burst.
module tb_wimax_derandomizer;
  import wimax_pkg::*;

`ifdef DERAND_LENCHK_EN
  localparam logic LEN_EXP = 1'b1;
`else
  localparam logic LEN_EXP = 1'b0;
`endif

  logic                clk;
  logic                reset;
  logic                en;
  logic                seed_sel;
  logic [LFSR_W-1:0]   load;
  logic [CNT_W-1:0]    burst_bits;
  logic                len_err;
  logic [7:0]          drop_cnt;
  derand_state_t       dbg_state;

  wimax_derandomizer_if bus ();

  wimax_derandomizer dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .seed_sel   (seed_sel),
    .load       (load),
    .burst_bits (burst_bits),
    .bus        (bus),
    .len_err    (len_err),
    .drop_cnt   (drop_cnt),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [95:0] in_vec;
  logic [95:0] out_vec;

  logic [2:0] exp_q[$];
  int         beat_cnt;
  int         valid_cyc;
  logic       eop_len_err;
  logic       sop_len_err;
  logic       bp_on;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // random backpressure
  initial begin
    forever begin
      @(negedge clk);
      if (bp_on) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // scoreboard / monitor
  initial begin
    logic [2:0] beat;
    logic [2:0] prev_beat;
    logic       stalled_prev;
    stalled_prev = 1'b0;
    prev_beat    = 3'b000;
    forever begin
      @(negedge clk);
      #2;
      beat = {bus.out_data, bus.out_sop, bus.out_eop};
      if (reset && stalled_prev) begin
        check_eq("stall_hold", 32'({bus.out_valid, beat}), 32'({1'b1, prev_beat}));
      end
      if (reset && bus.out_valid) valid_cyc++;
      if (reset && bus.out_valid && bus.out_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_beat", 32'(exp_q.size()), 32'(1));
        end else begin
          check_eq("out_beat", 32'(beat), 32'(exp_q.pop_front()));
        end
        if (bus.out_eop) eop_len_err = len_err;
        if (bus.out_sop) sop_len_err = len_err;
      end
      stalled_prev = reset && bus.out_valid && !bus.out_ready;
      prev_beat    = beat;
    end
  end

  // driver tasks
  task automatic send_bit(input logic d, input logic s, input logic e);
    int g;
    g = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sop   = s;
    bus.in_eop   = e;
    #1;
    while (!bus.in_ready && g < 200) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (g >= 200) check_eq("in_ready_timeout", 32'(g), 32'(0));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
  endtask

  task automatic pause_en();
    @(negedge clk);
    en = 1'b0;
    #1;
    check_eq("en0_ready", 32'(bus.in_ready), 32'(0));
    repeat (5) @(negedge clk);
    check_eq("en0_state", 32'(dbg_state), 32'(RUN));
    en = 1'b1;
  endtask

  task automatic send_burst(input logic [95:0] din, input logic [95:0] dexp,
                            input int nbits, input logic with_eop, input int pause_at);
    for (int i = 0; i < nbits; i++) begin
      logic [2:0] e;
      logic       last;
      last = with_eop && (i == nbits - 1);
      e = {dexp[95-i], (i == 0), last};
      exp_q.push_back(e);
      if (i == pause_at) pause_en();
      send_bit(din[95-i], (i == 0), last);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(negedge clk);
      #3;
      g++;
    end
    if (exp_q.size() != 0) begin
      check_eq("drain_timeout", 32'(exp_q.size()), 32'(0));
      exp_q.delete();
    end
  endtask

  initial begin
    in_vec        = 96'h558AC4A53A1724E163AC2BF9;
    out_vec       = 96'hACBCD2114DAE1577C6DBF4C9;
    reset         = 1'b0;
    en            = 1'b1;
    seed_sel      = 1'b0;
    load          = 15'h1234;
    burst_bits    = 16'd96;
    bus.in_valid  = 1'b0;
    bus.in_data   = 1'b0;
    bus.in_sop    = 1'b0;
    bus.in_eop    = 1'b0;
    bus.out_ready = 1'b1;
    bp_on         = 1'b0;
    beat_cnt      = 0;
    valid_cyc     = 0;
    eop_len_err   = 1'b0;
    sop_len_err   = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check_eq("rst_out_data", 32'(bus.out_data), 32'(0));
    check_eq("rst_out_sop", 32'(bus.out_sop), 32'(0));
    check_eq("rst_out_eop", 32'(bus.out_eop), 32'(0));
    check_eq("rst_len_err", 32'(len_err), 32'(0));
    check_eq("rst_drop_cnt", 32'(drop_cnt), 32'(0));
    check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b1;

    // stray bits outside a burst
    beat_cnt = 0;
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("stray_drop_cnt", 32'(drop_cnt), 32'(5));
    check_eq("stray_beats", 32'(beat_cnt), 32'(0));
    check_eq("stray_state", 32'(dbg_state), 32'(IDLE));

    // standard vector, no backpressure
    beat_cnt  = 0;
    valid_cyc = 0;
    send_burst(in_vec, out_vec, 96, 1'b1, -1);
    drain();
    repeat (3) @(negedge clk);
    check_eq("std_beats", 32'(beat_cnt), 32'(96));
    check_eq("std_valid_cycles", 32'(valid_cyc), 32'(96));
    check_eq("std_len_err", 32'(eop_len_err), 32'(0));
    check_eq("std_state", 32'(dbg_state), 32'(IDLE));

    // random backpressure
    beat_cnt = 0;
    bp_on    = 1'b1;
    send_burst(in_vec, out_vec, 96, 1'b1, -1);
    drain();
    bp_on = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("bp_beats", 32'(beat_cnt), 32'(96));

    // back-to-back bursts: default seed (load ignored, enable pause), then load=default seed
    beat_cnt = 0;
    seed_sel = 1'b0;
    load     = 15'h1234;
    send_burst(in_vec, out_vec, 96, 1'b1, 30);
    seed_sel = 1'b1;
    load     = 15'h3715;
    send_burst(in_vec, out_vec, 96, 1'b1, -1);
    drain();
    repeat (3) @(negedge clk);
    check_eq("reseed_beats", 32'(beat_cnt), 32'(192));
    check_eq("drop_unchanged", 32'(drop_cnt), 32'(5));

    // all-zero seed leaves the data untouched
    load = 15'h0000;
    send_burst(in_vec, in_vec, 96, 1'b1, -1);
    drain();
    seed_sel = 1'b0;

    // short burst: EOP on bit 90
    send_burst(in_vec, out_vec, 90, 1'b1, -1);
    drain();
    check_eq("short_len_err", 32'(eop_len_err), 32'(LEN_EXP));

    // burst aborted by a new SOP
    send_burst(in_vec, out_vec, 20, 1'b0, -1);
    drain();
    check_eq("abort_sop_clear", 32'(sop_len_err), 32'(0));
    check_eq("abort_state", 32'(dbg_state), 32'(RUN));
    send_burst(in_vec, out_vec, 96, 1'b1, -1);
    drain();
    check_eq("abort_sop_len_err", 32'(sop_len_err), 32'(LEN_EXP));
    check_eq("abort_eop_len_err", 32'(eop_len_err), 32'(LEN_EXP));

    // reset asserted after 40 bits of a burst
    send_burst(in_vec, out_vec, 40, 1'b0, -1);
    drain();
    reset = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", 32'(bus.out_valid), 32'(0));
    check_eq("mid_rst_out_data", 32'(bus.out_data), 32'(0));
    check_eq("mid_rst_out_sop", 32'(bus.out_sop), 32'(0));
    check_eq("mid_rst_drop_cnt", 32'(drop_cnt), 32'(0));
    check_eq("mid_rst_len_err", 32'(len_err), 32'(0));
    check_eq("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    reset    = 1'b1;
    beat_cnt = 0;
    send_burst(in_vec, out_vec, 96, 1'b1, -1);
    drain();
    repeat (3) @(negedge clk);
    check_eq("post_rst_beats", 32'(beat_cnt), 32'(96));
    check_eq("post_rst_len_err", 32'(eop_len_err), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
